// File: rtl/snes_ctrl_pkg.sv
// Shared types and constants for the SNES controller input path.
// Source encoding doubles as arbiter state and owner output.
package snes_ctrl_pkg;

    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_KB   = 2'b01,
        SRC_IR   = 2'b10,
        SRC_BTN  = 2'b11
    } src_e;

    typedef logic [7:0] snes_btn_t;

    localparam logic [1:0] MODE_AUTO = 2'b00;
    localparam logic [1:0] MODE_KB   = 2'b01;
    localparam logic [1:0] MODE_IR   = 2'b10;
    localparam logic [1:0] MODE_BTN  = 2'b11;

    // Forced modes map one-to-one onto the source they select.
    function automatic src_e mode_src(input logic [1:0] m);
        return src_e'(m);
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Ownership hold timer: reloads to HOLD_CYCLES-1, counts down to 0.
// expired is high while the count sits at 0.
module hold_timer #(
    parameter int HOLD_CYCLES = 100000
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [W-1:0] RELOAD = W'(HOLD_CYCLES - 1);
    localparam logic [W-1:0] ONE    = W'(1);

    logic [W-1:0] count;

    // Reload on load, otherwise count down while enabled and not yet at 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (enable && (count != '0)) begin
            count <= count - ONE;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/input_arbiter.sv
// Grants the SNES encoder data path to keyboard, IR or button board.
// Output byte is snapshotted only on latch rising edges.
module input_arbiter #(
    parameter int HOLD_CYCLES = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] kb_data,
    input  logic       kb_valid,
    input  logic [7:0] ir_data,
    input  logic       ir_valid,
    input  logic [7:0] btn_data,
    input  logic [1:0] mode,
    input  logic       latch,
    output logic [7:0] mux_en,
    output logic [1:0] owner
);

    import snes_ctrl_pkg::*;

    src_e      state;
    src_e      state_d;
    src_e      last_owner;
    src_e      last_owner_d;
    src_e      pick;
    logic      forced_q;
    logic      latch_q;
    logic      frame;
    snes_btn_t kb_reg;
    snes_btn_t ir_reg;
    snes_btn_t mux_q;
    snes_btn_t sel_byte;

    logic req_kb;
    logic req_ir;
    logic req_btn;
    logic act_btn;
    logic act_own;
    logic tmr_load;
    logic tmr_en;
    logic tmr_expired;

    assign act_btn = (btn_data != 8'h00);
    assign req_kb  = kb_valid && (kb_data != 8'h00);
    assign req_ir  = ir_valid && (ir_data != 8'h00);
    assign req_btn = act_btn;
    assign frame   = latch && !latch_q;

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clock  (clock),
        .reset  (reset),
        .load   (tmr_load),
        .enable (tmr_en),
        .expired(tmr_expired)
    );

    // Round-robin pick, searching from the source after last_owner.
    always_comb begin
        pick = SRC_NONE;
        case (last_owner)
            SRC_KB: begin
                if (req_ir)       pick = SRC_IR;
                else if (req_btn) pick = SRC_BTN;
                else if (req_kb)  pick = SRC_KB;
            end
            SRC_IR: begin
                if (req_btn)      pick = SRC_BTN;
                else if (req_kb)  pick = SRC_KB;
                else if (req_ir)  pick = SRC_IR;
            end
            default: begin
                if (req_kb)       pick = SRC_KB;
                else if (req_ir)  pick = SRC_IR;
                else if (req_btn) pick = SRC_BTN;
            end
        endcase
    end

    // Activity from the current owner, and the byte it would present.
    always_comb begin
        act_own  = 1'b0;
        sel_byte = 8'h00;
        case (state)
            SRC_KB: begin
                act_own  = kb_valid;
                sel_byte = kb_reg;
            end
            SRC_IR: begin
                act_own  = ir_valid;
                sel_byte = ir_reg;
            end
            SRC_BTN: begin
                act_own  = act_btn;
                sel_byte = btn_data;
            end
            default: begin
                act_own  = 1'b0;
                sel_byte = 8'h00;
            end
        endcase
    end

    // Next owner and hold-timer control.
    always_comb begin
        state_d      = state;
        last_owner_d = last_owner;
        tmr_load     = 1'b0;
        tmr_en       = 1'b0;
        if (mode != MODE_AUTO) begin
            state_d  = mode_src(mode);
            tmr_load = 1'b1;
        end else if (forced_q) begin
            state_d = SRC_NONE;
        end else if (state == SRC_NONE) begin
            if (pick != SRC_NONE) begin
                state_d      = pick;
                last_owner_d = pick;
                tmr_load     = 1'b1;
            end
        end else if (act_own) begin
            tmr_load = 1'b1;
        end else if (tmr_expired) begin
            state_d = SRC_NONE;
        end else begin
            tmr_en = 1'b1;
        end
    end

    // Owner state, round-robin pointer and forced-mode memory.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= SRC_NONE;
            last_owner <= SRC_BTN;
            forced_q   <= 1'b0;
        end else begin
            state      <= state_d;
            last_owner <= last_owner_d;
            forced_q   <= (mode != MODE_AUTO);
        end
    end

    // Capture registers for the strobed sources.
    always_ff @(posedge clock) begin
        if (reset) begin
            kb_reg <= 8'h00;
            ir_reg <= 8'h00;
        end else begin
            if (kb_valid) kb_reg <= kb_data;
            if (ir_valid) ir_reg <= ir_data;
        end
    end

    // Frame-aligned snapshot of the owner's byte.
    always_ff @(posedge clock) begin
        if (reset) begin
            latch_q <= 1'b0;
            mux_q   <= 8'h00;
        end else begin
            latch_q <= latch;
            if (frame) mux_q <= sel_byte;
        end
    end

    assign mux_en = mux_q;
    assign owner  = state;

endmodule
